// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with load-use bubble, capture bypass and MEM/WB forwarding
module id_ex_reg #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [RA_W-1:0] id_rd_addr,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [3:0]      id_alu_control,
    input  logic            id_alu_src_a,
    input  logic            id_alu_src_b,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [2:0]      id_funct3,
    input  logic            hold,
    input  logic            flush_ex,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] mem_rd_addr,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_reg_write,
    input  logic [RA_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic [3:0]      ALUControl,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rd_addr,
    output logic [2:0]      ex_funct3,
    output logic            stall_id
);

    logic            valid_q,      valid_d;
    logic [XLEN-1:0] pc_q,         pc_d;
    logic [XLEN-1:0] rs1_data_q,   rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,   rs2_data_d;
    logic [XLEN-1:0] imm_q,        imm_d;
    logic [RA_W-1:0] rs1_addr_q,   rs1_addr_d;
    logic [RA_W-1:0] rs2_addr_q,   rs2_addr_d;
    logic [RA_W-1:0] rd_addr_q,    rd_addr_d;
    logic [3:0]      alu_ctrl_q,   alu_ctrl_d;
    logic            alu_src_a_q,  alu_src_a_d;
    logic            alu_src_b_q,  alu_src_b_d;
    logic            reg_write_q,  reg_write_d;
    logic            mem_read_q,   mem_read_d;
    logic            mem_write_q,  mem_write_d;
    logic [2:0]      funct3_q,     funct3_d;

    logic            lu;
    logic            bubble;
    logic            wb_hit_rs1_id, wb_hit_rs2_id;
    logic [XLEN-1:0] rs1_f, rs2_f;

    // A load in EX whose rd is read by the instruction in ID cannot be forwarded in time.
    always_comb begin
        lu = valid_q & mem_read_q & (rd_addr_q != '0) & id_valid &
             ((id_uses_rs1 & (id_rs1_addr == rd_addr_q)) |
              (id_uses_rs2 & (id_rs2_addr == rd_addr_q)));
        stall_id = hold | (lu & ~flush_ex);
        bubble   = flush_ex | lu | ~id_valid;
    end

    // The register file write happening this cycle is not yet visible in id_rs*_data.
    always_comb begin
        wb_hit_rs1_id = wb_reg_write & (wb_rd_addr != '0) & (wb_rd_addr == id_rs1_addr);
        wb_hit_rs2_id = wb_reg_write & (wb_rd_addr != '0) & (wb_rd_addr == id_rs2_addr);
    end

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_src_a_d = alu_src_a_q;
        alu_src_b_d = alu_src_b_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        funct3_d    = funct3_q;
        if (!hold) begin
            if (bubble) begin
                valid_d     = 1'b0;
                pc_d        = '0;
                rs1_data_d  = '0;
                rs2_data_d  = '0;
                imm_d       = '0;
                rs1_addr_d  = '0;
                rs2_addr_d  = '0;
                rd_addr_d   = '0;
                alu_ctrl_d  = '0;
                alu_src_a_d = 1'b0;
                alu_src_b_d = 1'b0;
                reg_write_d = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                funct3_d    = '0;
            end else begin
                valid_d     = 1'b1;
                pc_d        = id_pc;
                rs1_data_d  = wb_hit_rs1_id ? wb_data : id_rs1_data;
                rs2_data_d  = wb_hit_rs2_id ? wb_data : id_rs2_data;
                imm_d       = id_imm;
                rs1_addr_d  = id_rs1_addr;
                rs2_addr_d  = id_rs2_addr;
                rd_addr_d   = id_rd_addr;
                alu_ctrl_d  = id_alu_control;
                alu_src_a_d = id_alu_src_a;
                alu_src_b_d = id_alu_src_b;
                reg_write_d = id_reg_write;
                mem_read_d  = id_mem_read;
                mem_write_d = id_mem_write;
                funct3_d    = id_funct3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            alu_ctrl_q  <= '0;
            alu_src_a_q <= 1'b0;
            alu_src_b_q <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            funct3_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_src_a_q <= alu_src_a_d;
            alu_src_b_q <= alu_src_b_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            funct3_q    <= funct3_d;
        end
    end

    // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
    always_comb begin
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs1_addr_q))
            rs1_f = mem_fwd_data;
        else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs1_addr_q))
            rs1_f = wb_data;
        else
            rs1_f = rs1_data_q;

        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs2_addr_q))
            rs2_f = mem_fwd_data;
        else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs2_addr_q))
            rs2_f = wb_data;
        else
            rs2_f = rs2_data_q;
    end

    assign operand_a     = alu_src_a_q ? pc_q  : rs1_f;
    assign operand_b     = alu_src_b_q ? imm_q : rs2_f;
    assign ex_store_data = rs2_f;
    assign ALUControl    = alu_ctrl_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_pc         = pc_q;
    assign ex_imm        = imm_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_funct3     = funct3_q;

endmodule
